// File: rtl/hack_cpu_mc.sv
// ============================================================================
// Module   : hack_cpu_mc
// Purpose  : Multi-cycle Hack CPU core with a configurable data width.
//            Executes the 16-bit Hack A/C instruction set. Instruction fetch
//            and data (M operand) accesses use valid/ack handshakes, so
//            wait-stated ROM and RAM are tolerated.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            instr_req/addr     - fetch request and address (addr = pc)
//            instr_data/valid   - fetched word and completion strobe
//            mem_req/we/addr    - data access request, direction, address
//            mem_wdata/rdata    - write data / read data
//            mem_ack            - data access completion
//            pc, a_reg, d_reg   - architectural state
//            retire             - one-cycle pulse per completed instruction
//            halted             - high while parked in the idle-loop halt
// Config   : HACK_CPU_HALT_EN   - when defined, a taken jump to its own pc
//                                 parks the core in HALT until reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module hack_cpu_mc #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 15,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              instr_req,
    output logic [PC_W-1:0]   instr_addr,
    input  logic [15:0]       instr_data,
    input  logic              instr_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] a_reg,
    output logic [DATA_W-1:0] d_reg,
    output logic              retire,
    output logic              halted
);

    localparam logic [PC_W-1:0] c_PC_ONE = PC_W'(1);

`ifdef HACK_CPU_HALT_EN
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM_RD = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM_WR = 3'd4,
        S_HALT   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM_RD = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM_WR = 3'd4
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   dr_q, dr_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   m_q, m_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   ea_q, ea_d;
    // pc to commit once a deferred M write completes
    logic [PC_W-1:0]     npc_q, npc_d;
`ifdef HACK_CPU_HALT_EN
    // remembers that the instruction waiting on its M write was a self-jump
    logic                halt_pend_q, halt_pend_d;
`endif

    // ------------------------------------------------------------------
    // Instruction field decode (C-instruction layout in ir[12:0])
    // ------------------------------------------------------------------
    logic w_a, w_zx, w_nx, w_zy, w_ny, w_f, w_no;
    logic w_d1, w_d2, w_d3, w_j1, w_j2, w_j3;

    assign w_a  = ir_q[12];
    assign w_zx = ir_q[11];
    assign w_nx = ir_q[10];
    assign w_zy = ir_q[9];
    assign w_ny = ir_q[8];
    assign w_f  = ir_q[7];
    assign w_no = ir_q[6];
    assign w_d1 = ir_q[5];
    assign w_d2 = ir_q[4];
    assign w_d3 = ir_q[3];
    assign w_j1 = ir_q[2];
    assign w_j2 = ir_q[1];
    assign w_j3 = ir_q[0];

    // ------------------------------------------------------------------
    // ALU, evaluated on the pre-instruction register values
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_x1, w_x2, w_y0, w_y1, w_y2, w_fo, w_alu;
    logic              w_zero, w_neg, w_pos, w_taken;
    logic [PC_W-1:0]   w_target, w_pc_inc, w_npc;

    assign w_y0  = w_a ? m_q : a_q;
    assign w_x1  = w_zx ? '0 : dr_q;
    assign w_x2  = w_nx ? ~w_x1 : w_x1;
    assign w_y1  = w_zy ? '0 : w_y0;
    assign w_y2  = w_ny ? ~w_y1 : w_y1;
    assign w_fo  = w_f ? (w_x2 + w_y2) : (w_x2 & w_y2);
    assign w_alu = w_no ? ~w_fo : w_fo;

    assign w_zero  = (w_alu == '0);
    assign w_neg   = w_alu[DATA_W-1];
    assign w_pos   = !w_zero && !w_neg;
    assign w_taken = (w_j1 && w_neg) || (w_j2 && w_zero) || (w_j3 && w_pos);

    assign w_target = a_q[PC_W-1:0];
    assign w_pc_inc = pc_q + c_PC_ONE;
    assign w_npc    = w_taken ? w_target : w_pc_inc;

`ifdef HACK_CPU_HALT_EN
    logic w_self;
    assign w_self = w_taken && (w_target == pc_q);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            a_q         <= '0;
            dr_q        <= '0;
            ir_q        <= '0;
            m_q         <= '0;
            wdata_q     <= '0;
            ea_q        <= '0;
            npc_q       <= '0;
`ifdef HACK_CPU_HALT_EN
            halt_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            dr_q        <= dr_d;
            ir_q        <= ir_d;
            m_q         <= m_d;
            wdata_q     <= wdata_d;
            ea_q        <= ea_d;
            npc_q       <= npc_d;
`ifdef HACK_CPU_HALT_EN
            halt_pend_q <= halt_pend_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    logic w_instr_req, w_mem_req, w_mem_we, w_retire, w_halted;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        dr_d        = dr_q;
        ir_d        = ir_q;
        m_d         = m_q;
        wdata_d     = wdata_q;
        ea_d        = ea_q;
        npc_d       = npc_q;
`ifdef HACK_CPU_HALT_EN
        halt_pend_d = halt_pend_q;
`endif
        w_instr_req = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_retire    = 1'b0;
        w_halted    = 1'b0;

        case (state_q)
            S_FETCH: begin
                w_instr_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr_data;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (!ir_q[15]) begin
                    a_d      = DATA_W'(ir_q[14:0]);
                    pc_d     = w_pc_inc;
                    w_retire = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    ea_d    = a_q[ADDR_W-1:0];
                    state_d = w_a ? S_MEM_RD : S_EXEC;
                end
            end

            S_MEM_RD: begin
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    m_d     = mem_rdata;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (w_d1) begin
                    a_d = w_alu;
                end
                if (w_d2) begin
                    dr_d = w_alu;
                end
                if (w_d3) begin
                    // jump outcome is resolved now, while A and D still hold
                    // their pre-instruction values; commit it after the write
                    wdata_d = w_alu;
                    npc_d   = w_npc;
`ifdef HACK_CPU_HALT_EN
                    halt_pend_d = w_self;
`endif
                    state_d = S_MEM_WR;
                end else begin
                    pc_d     = w_npc;
                    w_retire = 1'b1;
`ifdef HACK_CPU_HALT_EN
                    state_d  = w_self ? S_HALT : S_FETCH;
`else
                    state_d  = S_FETCH;
`endif
                end
            end

            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                if (mem_ack) begin
                    pc_d     = npc_q;
                    w_retire = 1'b1;
`ifdef HACK_CPU_HALT_EN
                    state_d  = halt_pend_q ? S_HALT : S_FETCH;
`else
                    state_d  = S_FETCH;
`endif
                end
            end

`ifdef HACK_CPU_HALT_EN
            S_HALT: begin
                w_halted = 1'b1;
            end
`endif

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Control outputs are forced low while reset is asserted so an
    // in-flight handshake is abandoned immediately.
    assign instr_req  = w_instr_req & ~reset;
    assign mem_req    = w_mem_req & ~reset;
    assign mem_we     = w_mem_we & ~reset;
    assign retire     = w_retire & ~reset;
    assign halted     = w_halted & ~reset;

    assign instr_addr = pc_q;
    assign mem_addr   = ea_q;
    assign mem_wdata  = wdata_q;
    assign pc         = pc_q;
    assign a_reg      = a_q;
    assign d_reg      = dr_q;

endmodule

`default_nettype wire

// File: tb/tb_hack_cpu_mc.sv
// ============================================================================
// Module   : tb_hack_cpu_mc
// Purpose  : Directed self-checking bench for hack_cpu_mc (16-bit and 32-bit
//            data-width instances) with wait-stated ROM/RAM responders.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hack_cpu_mc;

    int tests = 0;
    int fails = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;

    initial forever #5 clk = ~clk;

    // 16-bit instance
    logic        instr_req, instr_valid, mem_req, mem_we, mem_ack, retire, halted;
    logic [14:0] instr_addr, mem_addr, pc;
    logic [15:0] instr_data, mem_wdata, mem_rdata, a_reg, d_reg;

    hack_cpu_mc #(.DATA_W(16), .PC_W(15), .ADDR_W(15)) u_dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_data(instr_data), .instr_valid(instr_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg),
        .retire(retire), .halted(halted)
    );

    // 32-bit instance (no data memory attached)
    logic        instr_req32, instr_valid32, mem_req32, mem_we32, mem_ack32;
    logic        retire32, halted32;
    logic [14:0] instr_addr32, mem_addr32, pc32;
    logic [15:0] instr_data32;
    logic [31:0] mem_wdata32, mem_rdata32, a32, d32;

    hack_cpu_mc #(.DATA_W(32), .PC_W(15), .ADDR_W(15)) u_dut32 (
        .clk(clk), .reset(reset),
        .instr_req(instr_req32), .instr_addr(instr_addr32),
        .instr_data(instr_data32), .instr_valid(instr_valid32),
        .mem_req(mem_req32), .mem_we(mem_we32), .mem_addr(mem_addr32),
        .mem_wdata(mem_wdata32), .mem_rdata(mem_rdata32), .mem_ack(mem_ack32),
        .pc(pc32), .a_reg(a32), .d_reg(d32),
        .retire(retire32), .halted(halted32)
    );

    logic [15:0] rom   [0:255];
    logic [15:0] rom32 [0:255];
    logic [15:0] ram   [0:255];
    int rom_dly = 0;
    int ram_dly = 0;

    int          n_rd, n_wr, stab_bad;
    logic [14:0] rd_addr_log [0:7];
    logic [14:0] wr_addr_log [0:7];
    logic [15:0] wr_data_log [0:7];

    // ROM responder for the 16-bit core
    initial begin
        int cnt;
        cnt = 0;
        instr_valid = 1'b0;
        instr_data  = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (instr_req) begin
                if (cnt >= rom_dly) begin
                    instr_valid = 1'b1;
                    instr_data  = rom[instr_addr[7:0]];
                end else begin
                    instr_valid = 1'b0;
                    cnt++;
                end
            end else begin
                instr_valid = 1'b0;
                cnt = 0;
            end
        end
    end

    // Zero-wait ROM responder for the 32-bit core
    initial begin
        instr_valid32 = 1'b0;
        instr_data32  = 16'h0000;
        mem_ack32     = 1'b0;
        mem_rdata32   = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            instr_valid32 = instr_req32;
            instr_data32  = rom32[instr_addr32[7:0]];
        end
    end

    // RAM responder with programmable wait states and request-stability log
    initial begin
        int          cnt;
        logic        waiting;
        logic [14:0] p_addr;
        logic        p_we;
        logic [15:0] p_wdata;
        cnt = 0;
        waiting = 1'b0;
        p_addr = '0;
        p_we = 1'b0;
        p_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) begin
                if (waiting && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
                    stab_bad++;
                if (cnt >= ram_dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = ram[mem_addr[7:0]];
                    waiting = 1'b0;
                    if (mem_we) begin
                        ram[mem_addr[7:0]] = mem_wdata;
                        if (n_wr < 8) begin
                            wr_addr_log[n_wr] = mem_addr;
                            wr_data_log[n_wr] = mem_wdata;
                        end
                        n_wr++;
                    end else begin
                        if (n_rd < 8) rd_addr_log[n_rd] = mem_addr;
                        n_rd++;
                    end
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                    waiting = 1'b1;
                    p_addr = mem_addr;
                    p_we = mem_we;
                    p_wdata = mem_wdata;
                end
            end else begin
                mem_ack = 1'b0;
                cnt = 0;
                waiting = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'h0000;
            rom32[i] = 16'h0000;
            ram[i] = 16'h0000;
        end
        n_rd = 0;
        n_wr = 0;
        stab_bad = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Waits for n retire pulses (16-bit core), then one more negedge so the
    // retired instruction's register updates are visible. lc = cycle of the
    // n-th retire counted from reset release, 0 on timeout.
    task automatic run_retire(input int n, input int maxc, output int lc);
        int cnt;
        cnt = 0;
        lc = 0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (retire === 1'b1) begin
                cnt++;
                if (cnt == n) begin
                    lc = c;
                    break;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({instr_req, mem_req, mem_we, retire, halted} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 00000", {instr_req, mem_req, mem_we, retire, halted});
        end
        tests++;
        if ({pc, a_reg, d_reg} !== 47'h0) begin
            fails++;
            $display("FAIL reset_regs: pc=%h a=%h d=%h expected all 0", pc, a_reg, d_reg);
        end
        tests++;
        if ({mem_addr, mem_wdata, instr_addr} !== 46'h0) begin
            fails++;
            $display("FAIL reset_addr: maddr=%h wdata=%h iaddr=%h expected all 0", mem_addr, mem_wdata, instr_addr);
        end
        tests++;
        if ({instr_req32, mem_req32, mem_we32, retire32, halted32, pc32, a32, d32, mem_addr32, mem_wdata32, instr_addr32} !== 0) begin
            fails++;
            $display("FAIL reset_w32: pc=%h a=%h d=%h req=%b expected all 0", pc32, a32, d32, instr_req32);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({instr_req, instr_addr} !== {1'b1, 15'h0}) begin
            fails++;
            $display("FAIL first_fetch: req=%b addr=%h expected req=1 addr=0", instr_req, instr_addr);
        end
    endtask

    task automatic test_fetch_wait();
        int lc;
        clear_mem();
        rom[0] = 16'h0005;
        rom_dly = 3;
        apply_reset();
        run_retire(1, 20, lc);
        tests++;
        if (lc !== 5) begin
            fails++;
            $display("FAIL fetch_wait_cycle: got %0d expected 5", lc);
        end
        tests++;
        if ({a_reg, pc} !== {16'd5, 15'd1}) begin
            fails++;
            $display("FAIL fetch_wait_regs: a=%0d pc=%0d expected a=5 pc=1", a_reg, pc);
        end
        rom_dly = 0;
    endtask

    task automatic test_program();
        logic [31:0] mask;
        clear_mem();
        rom[0] = 16'h0005;  // @5
        rom[1] = 16'hEC10;  // D=A
        rom[2] = 16'h0007;  // @7
        rom[3] = 16'hE090;  // D=D+A
        mask = '0;
        apply_reset();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (retire === 1'b1) mask[c] = 1'b1;
        end
        @(negedge clk);
        tests++;
        if (mask !== 32'h0000_04A4) begin
            fails++;
            $display("FAIL prog_retire_cycles: got %h expected 000004a4", mask);
        end
        tests++;
        if ({d_reg, a_reg, pc} !== {16'd12, 16'd7, 15'd4}) begin
            fails++;
            $display("FAIL prog_regs: d=%0d a=%0d pc=%0d expected d=12 a=7 pc=4", d_reg, a_reg, pc);
        end
    endtask

    task automatic test_mem_rmw();
        int lc;
        clear_mem();
        rom[0] = 16'h0003;  // @3
        rom[1] = 16'hFDC8;  // M=M+1
        ram[3] = 16'd9;
        ram_dly = 2;
        apply_reset();
        run_retire(2, 60, lc);
        tests++;
        if (lc !== 11) begin
            fails++;
            $display("FAIL rmw_cycle: got %0d expected 11", lc);
        end
        tests++;
        if (n_rd !== 1 || rd_addr_log[0] !== 15'd3) begin
            fails++;
            $display("FAIL rmw_read: reads=%0d addr=%0d expected 1 read at 3", n_rd, rd_addr_log[0]);
        end
        tests++;
        if (n_wr !== 1 || wr_addr_log[0] !== 15'd3 || wr_data_log[0] !== 16'd10) begin
            fails++;
            $display("FAIL rmw_write: writes=%0d addr=%0d data=%0d expected 1 write 10 at 3", n_wr, wr_addr_log[0], wr_data_log[0]);
        end
        tests++;
        if (stab_bad !== 0) begin
            fails++;
            $display("FAIL rmw_stable: got %0d changes expected 0", stab_bad);
        end
        tests++;
        if (pc !== 15'd2) begin
            fails++;
            $display("FAIL rmw_pc: got %0d expected 2", pc);
        end
        ram_dly = 0;
    endtask

    task automatic test_am();
        int lc;
        clear_mem();
        rom[0] = 16'h0014;  // @20
        rom[1] = 16'hFCA8;  // AM=M-1
        ram[20] = 16'd4;
        apply_reset();
        run_retire(2, 30, lc);
        tests++;
        if (lc !== 7) begin
            fails++;
            $display("FAIL am_cycle: got %0d expected 7", lc);
        end
        tests++;
        if (n_wr !== 1 || wr_addr_log[0] !== 15'd20 || wr_data_log[0] !== 16'd3) begin
            fails++;
            $display("FAIL am_write: writes=%0d addr=%0d data=%0d expected 1 write 3 at 20", n_wr, wr_addr_log[0], wr_data_log[0]);
        end
        tests++;
        if ({a_reg, pc} !== {16'd3, 15'd2}) begin
            fails++;
            $display("FAIL am_regs: a=%0d pc=%0d expected a=3 pc=2", a_reg, pc);
        end
    endtask

    task automatic test_jumps();
        logic [15:0] dset [0:2];
        logic [15:0] jset [0:3];
        int          dval [0:2];
        int          lc;
        logic        tk;
        logic [14:0] exp_pc;
        dset[0] = 16'hEE90; dval[0] = -1;  // D=-1
        dset[1] = 16'hEA90; dval[1] = 0;   // D=0
        dset[2] = 16'hEFD0; dval[2] = 1;   // D=1
        jset[0] = 16'hE304;                // D;JLT
        jset[1] = 16'hE302;                // D;JEQ
        jset[2] = 16'hE301;                // D;JGT
        jset[3] = 16'hE307;                // D;JMP
        for (int di = 0; di < 3; di++) begin
            for (int ji = 0; ji < 4; ji++) begin
                clear_mem();
                rom[0] = dset[di];
                rom[1] = 16'h0064;  // @100
                rom[2] = jset[ji];
                case (ji)
                    0: tk = (dval[di] < 0);
                    1: tk = (dval[di] == 0);
                    2: tk = (dval[di] > 0);
                    default: tk = 1'b1;
                endcase
                exp_pc = tk ? 15'd100 : 15'd3;
                apply_reset();
                run_retire(3, 30, lc);
                tests++;
                if (pc !== exp_pc || lc !== 8) begin
                    fails++;
                    $display("FAIL jump_d%0d_j%0d: pc=%0d cycle=%0d expected pc=%0d cycle=8", dval[di], ji, pc, lc, exp_pc);
                end
            end
        end
    endtask

    task automatic test_pc_wrap();
        int lc;
        clear_mem();
        rom[0]   = 16'h7FFF;  // @32767
        rom[1]   = 16'hEA87;  // 0;JMP
        rom[255] = 16'h0001;  // @1, fetched from 32767
        apply_reset();
        run_retire(3, 30, lc);
        tests++;
        if ({pc, a_reg, instr_addr} !== {15'd0, 16'd1, 15'd0}) begin
            fails++;
            $display("FAIL pc_wrap: pc=%0d a=%0d iaddr=%0d expected pc=0 a=1 iaddr=0", pc, a_reg, instr_addr);
        end
    endtask

    task automatic test_width32();
        int cnt;
        clear_mem();
        rom32[0] = 16'h0000;  // @0
        rom32[1] = 16'hEC90;  // D=A-1
        rom32[2] = 16'h0064;  // @100
        rom32[3] = 16'hE304;  // D;JLT
        apply_reset();
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 2; c++) begin
            @(negedge clk);
            if (retire32 === 1'b1) cnt++;
        end
        @(negedge clk);
        tests++;
        if (d32 !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL w32_d: got %h expected ffffffff", d32);
        end
        for (int c = 0; c < 20 && cnt < 4; c++) begin
            @(negedge clk);
            if (retire32 === 1'b1) cnt++;
        end
        @(negedge clk);
        tests++;
        if (pc32 !== 15'd100) begin
            fails++;
            $display("FAIL w32_jlt: pc=%0d expected 100", pc32);
        end
    endtask

    task automatic test_reset_mid_write();
        logic found;
        clear_mem();
        rom[0] = 16'h0003;  // @3
        rom[1] = 16'hFDC8;  // M=M+1
        ram[3] = 16'd9;
        ram_dly = 4;
        apply_reset();
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        tests++;
        if (found !== 1'b1) begin
            fails++;
            $display("FAIL midrst_reach_wr: got %b expected 1", found);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL midrst_req: got %b expected 0", mem_req);
        end
        tests++;
        if ({pc, a_reg, d_reg} !== 47'h0) begin
            fails++;
            $display("FAIL midrst_regs: pc=%h a=%h d=%h expected all 0", pc, a_reg, d_reg);
        end
        tests++;
        if (n_wr !== 0) begin
            fails++;
            $display("FAIL midrst_nowrite: got %0d writes expected 0", n_wr);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        ram_dly = 0;
    endtask

    task automatic test_halt();
        int lc;
        int reqs;
        clear_mem();
        rom[0] = 16'h0004;  // @4
        rom[1] = 16'hEA87;  // 0;JMP -> pc 4
        rom[4] = 16'hEA87;  // 0;JMP to itself (A still 4)
        apply_reset();
        run_retire(3, 30, lc);
`ifdef HACK_CPU_HALT_EN
        tests++;
        if ({halted, pc} !== {1'b1, 15'd4}) begin
            fails++;
            $display("FAIL halt_enter: halted=%b pc=%0d expected halted=1 pc=4", halted, pc);
        end
        reqs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (instr_req !== 1'b0 || mem_req !== 1'b0) reqs++;
        end
        tests++;
        if (reqs !== 0 || halted !== 1'b1) begin
            fails++;
            $display("FAIL halt_quiet: got %0d request cycles halted=%b expected 0 and 1", reqs, halted);
        end
`else
        tests++;
        if ({halted, pc} !== {1'b0, 15'd4}) begin
            fails++;
            $display("FAIL selfjump_first: halted=%b pc=%0d expected halted=0 pc=4", halted, pc);
        end
        reqs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (retire === 1'b1) reqs++;
        end
        tests++;
        if (reqs === 0 || halted !== 1'b0 || pc !== 15'd4) begin
            fails++;
            $display("FAIL selfjump_loop: retires=%0d halted=%b pc=%0d expected >0, 0, 4", reqs, halted, pc);
        end
`endif
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_fetch_wait();
        test_program();
        test_mem_rmw();
        test_am();
        test_jumps();
        test_pc_wrap();
        test_width32();
        test_reset_mid_write();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
